// File: rtl/fft_mag_peak.sv
// Squared-magnitude stage for the FFT output stream: checks sop/eop framing,
// forwards |X|^2 per bin with latency 2 and reports the in-window peak per good frame.
module fft_mag_peak #(
  parameter int FFT_LEN   = 128,
  parameter int DW        = 16,
  parameter int IDX_W     = 7,
  parameter int SEARCH_LO = 1,
  parameter int SEARCH_HI = 63
) (
  input  logic                 clk_100m,
  input  logic                 rst_n,
  input  logic                 fft_src_valid,
  input  logic                 fft_src_sop,
  input  logic                 fft_src_eop,
  input  logic signed [DW-1:0] fft_src_real,
  input  logic signed [DW-1:0] fft_src_imag,
  output logic                 fft_src_ready,
  output logic                 mag_valid,
  output logic                 mag_sop,
  output logic                 mag_eop,
  output logic [IDX_W-1:0]     mag_idx,
  output logic [2*DW-1:0]      mag_data,
  output logic                 peak_valid,
  output logic [IDX_W-1:0]     peak_idx,
  output logic [2*DW-1:0]      peak_mag,
  output logic                 frame_err,
  output logic [15:0]          frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);
  localparam logic [IDX_W-1:0] LO_IDX   = IDX_W'(SEARCH_LO);
  localparam logic [IDX_W-1:0] HI_IDX   = IDX_W'(SEARCH_HI);

  typedef enum logic {
    S_IDLE,
    S_FRAME
  } state_e;

  state_e state_q, state_d;
  logic [IDX_W-1:0] bin_q, bin_d;

  logic                 ready_q;
  logic                 in_vld_q, in_sop_q, in_eop_q;
  logic signed [DW-1:0] in_re_q, in_im_q;

  logic                 fwd_d, fwd_sop_d, fwd_eop_d, err_d;
  logic [IDX_W-1:0]     fwd_idx_d;
  logic                 err_q;

  logic                 s1_vld_q, s1_sop_q, s1_eop_q;
  logic [IDX_W-1:0]     s1_idx_q;
  logic [2*DW-1:0]      s1_re2_q, s1_im2_q;

  logic                 mag_vld_q, mag_sop_q, mag_eop_q;
  logic [IDX_W-1:0]     mag_idx_q;
  logic [2*DW-1:0]      mag_data_q;

  logic [2*DW-1:0]      run_max_q, base_max, new_max;
  logic [IDX_W-1:0]     run_idx_q, base_idx, new_idx;
  logic                 peak_vld_q;
  logic [IDX_W-1:0]     peak_idx_q;
  logic [2*DW-1:0]      peak_mag_q;
  logic [15:0]          frame_cnt_q;

  logic signed [2*DW-1:0] re_ext, im_ext, re_sq, im_sq;

  // Sign-extend first so the square is computed at full output width.
  assign re_ext = {{DW{in_re_q[DW-1]}}, in_re_q};
  assign im_ext = {{DW{in_im_q[DW-1]}}, in_im_q};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      in_vld_q <= 1'b0;
      in_sop_q <= 1'b0;
      in_eop_q <= 1'b0;
      in_re_q  <= '0;
      in_im_q  <= '0;
    end else begin
      ready_q  <= 1'b1;
      in_vld_q <= fft_src_valid & ready_q;
      in_sop_q <= fft_src_sop;
      in_eop_q <= fft_src_eop;
      in_re_q  <= fft_src_real;
      in_im_q  <= fft_src_imag;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    fwd_d     = 1'b0;
    fwd_sop_d = 1'b0;
    fwd_eop_d = 1'b0;
    fwd_idx_d = bin_q;
    err_d     = 1'b0;
    if (in_vld_q) begin
      unique case (state_q)
        S_IDLE: begin
          if (in_sop_q) begin
            if (in_eop_q && FFT_LEN > 1) begin
              err_d = 1'b1;
            end else begin
              fwd_d     = 1'b1;
              fwd_sop_d = 1'b1;
              fwd_idx_d = '0;
              if (in_eop_q) begin
                fwd_eop_d = 1'b1;
              end else begin
                state_d = S_FRAME;
                bin_d   = IDX_W'(1);
              end
            end
          end
        end
        S_FRAME: begin
          if (in_sop_q) begin
            // Restart: abort the current frame and treat this beat as bin 0.
            err_d = 1'b1;
            if (in_eop_q && FFT_LEN > 1) begin
              state_d = S_IDLE;
            end else begin
              fwd_d     = 1'b1;
              fwd_sop_d = 1'b1;
              fwd_idx_d = '0;
              bin_d     = IDX_W'(1);
            end
          end else if (bin_q == LAST_IDX) begin
            fwd_d     = 1'b1;
            fwd_eop_d = in_eop_q;
            err_d     = ~in_eop_q;
            state_d   = S_IDLE;
          end else if (in_eop_q) begin
            fwd_d   = 1'b1;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            fwd_d = 1'b1;
            bin_d = bin_q + IDX_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bin_q    <= '0;
      err_q    <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_sop_q <= 1'b0;
      s1_eop_q <= 1'b0;
      s1_idx_q <= '0;
      s1_re2_q <= '0;
      s1_im2_q <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      err_q    <= err_d;
      s1_vld_q <= fwd_d;
      s1_sop_q <= fwd_sop_d;
      s1_eop_q <= fwd_eop_d;
      if (fwd_d) begin
        s1_idx_q <= fwd_idx_d;
        s1_re2_q <= unsigned'(re_sq);
        s1_im2_q <= unsigned'(im_sq);
      end
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      mag_vld_q  <= 1'b0;
      mag_sop_q  <= 1'b0;
      mag_eop_q  <= 1'b0;
      mag_idx_q  <= '0;
      mag_data_q <= '0;
    end else begin
      mag_vld_q <= s1_vld_q;
      mag_sop_q <= s1_sop_q;
      mag_eop_q <= s1_eop_q;
      if (s1_vld_q) begin
        mag_idx_q  <= s1_idx_q;
        mag_data_q <= s1_re2_q + s1_im2_q;
      end
    end
  end

  // Strict greater-than keeps the lowest bin on ties.
  always_comb begin
    base_max = run_max_q;
    base_idx = run_idx_q;
    if (mag_sop_q) begin
      base_max = '0;
      base_idx = LO_IDX;
    end
    new_max = base_max;
    new_idx = base_idx;
    if (mag_idx_q >= LO_IDX && mag_idx_q <= HI_IDX && mag_data_q > base_max) begin
      new_max = mag_data_q;
      new_idx = mag_idx_q;
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      run_max_q   <= '0;
      run_idx_q   <= '0;
      peak_vld_q  <= 1'b0;
      peak_idx_q  <= '0;
      peak_mag_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      peak_vld_q <= 1'b0;
      if (mag_vld_q) begin
        run_max_q <= new_max;
        run_idx_q <= new_idx;
        if (mag_eop_q) begin
          peak_vld_q  <= 1'b1;
          peak_idx_q  <= new_idx;
          peak_mag_q  <= new_max;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end
      end
    end
  end

  assign fft_src_ready = ready_q;
  assign mag_valid     = mag_vld_q;
  assign mag_sop       = mag_sop_q;
  assign mag_eop       = mag_eop_q;
  assign mag_idx       = mag_idx_q;
  assign mag_data      = mag_data_q;
  assign peak_valid    = peak_vld_q;
  assign peak_idx      = peak_idx_q;
  assign peak_mag      = peak_mag_q;
  assign frame_err     = err_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_fft_mag_peak.sv
// Bench for fft_mag_peak: frame-level reference model predicts every output
// cycle by cycle; directed frames plus randomized framing/gap stimulus.
module tb_fft_mag_peak;

  localparam int LEN = 128;
  localparam int LO  = 1;
  localparam int HI  = 63;

  logic               clk_100m = 1'b0;
  logic               rst_n    = 1'b1;
  logic               src_valid = 1'b0, src_sop = 1'b0, src_eop = 1'b0;
  logic signed [15:0] src_re = '0, src_im = '0;
  logic               fft_src_ready, mag_valid, mag_sop, mag_eop, peak_valid, frame_err;
  logic [6:0]         mag_idx, peak_idx;
  logic [31:0]        mag_data, peak_mag;
  logic [15:0]        frame_cnt;

  fft_mag_peak #(.FFT_LEN(LEN), .DW(16), .IDX_W(7), .SEARCH_LO(LO), .SEARCH_HI(HI)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n),
    .fft_src_valid(src_valid), .fft_src_sop(src_sop), .fft_src_eop(src_eop),
    .fft_src_real(src_re), .fft_src_imag(src_im), .fft_src_ready(fft_src_ready),
    .mag_valid(mag_valid), .mag_sop(mag_sop), .mag_eop(mag_eop),
    .mag_idx(mag_idx), .mag_data(mag_data),
    .peak_valid(peak_valid), .peak_idx(peak_idx), .peak_mag(peak_mag),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk_100m = ~clk_100m;

  int edge_n = 0;
  always @(posedge clk_100m) edge_n <= edge_n + 1;

  typedef struct packed {logic sop; logic eop; logic [6:0] idx; logic [31:0] data;} mexp_t;
  typedef struct packed {logic [6:0] idx; logic [31:0] mag; logic [15:0] cnt;} pexp_t;

  // Expected events keyed by the clock edge after which they become visible.
  bit    exp_err[int];
  mexp_t exp_mag[int];
  pexp_t exp_pk[int];

  int checks = 0, errors = 0;
  int rel_edge = 1 << 30;

  bit          m_in;
  int          m_pos;
  longint      m_mag[LEN];
  logic [15:0] m_cnt;

  logic signed [15:0] fr_re[LEN], fr_im[LEN];

  task automatic chk(input string name, input longint act, input longint want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, want, $time);
    end
  endtask

  // Frame-level reference: a frame is bins 0..LEN-1 starting at sop and ending with eop.
  task automatic model_beat(input int n, input bit s, input bit e, input int r, input int i);
    longint mg;
    bit start, last, good;
    int pidx;
    longint pmag;
    mg = longint'(r) * r + longint'(i) * i;
    start = 0;
    if (!m_in) begin
      if (!s) return;
      if (e) begin exp_err[n+1] = 1; return; end
      start = 1;
    end else if (s) begin
      exp_err[n+1] = 1;
      if (e) begin m_in = 0; return; end
      start = 1;
    end
    if (start) begin m_in = 1; m_pos = 0; end
    last = (m_pos == LEN - 1);
    good = last && e;
    if ((last || e) && !good) exp_err[n+1] = 1;
    m_mag[m_pos] = mg;
    exp_mag[n+2] = '{sop: start, eop: good, idx: 7'(m_pos), data: 32'(mg)};
    if (good) begin
      pidx = LO;
      pmag = 0;
      for (int b = LO; b <= HI; b++)
        if (m_mag[b] > pmag) begin pmag = m_mag[b]; pidx = b; end
      m_cnt = m_cnt + 16'd1;
      exp_pk[n+3] = '{idx: 7'(pidx), mag: 32'(pmag), cnt: m_cnt};
    end
    if (last || e) m_in = 0;
    else m_pos++;
  endtask

  function automatic logic signed [15:0] rnd();
    logic signed [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 15) == 0) v = 16'h8000;
    return v;
  endfunction

  task automatic beat(input bit s, input bit e, input logic signed [15:0] r, input logic signed [15:0] i);
    src_valid = 1; src_sop = s; src_eop = e; src_re = r; src_im = i;
    model_beat(edge_n + 1, s, e, r, i);
    @(posedge clk_100m); #1;
    src_valid = 0; src_sop = 0; src_eop = 0;
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      src_valid = 0; src_sop = 1'($urandom); src_eop = 1'($urandom);
      src_re = rnd(); src_im = rnd();
      @(posedge clk_100m); #1;
    end
    src_sop = 0; src_eop = 0;
  endtask

  // gap: 0 contiguous, 1 alternating idle, 2 random idles
  task automatic send_frame(input int nbeats, input int eop_at, input int gap);
    for (int p = 0; p < nbeats; p++) begin
      if (gap == 1 && p > 0) idle(1);
      if (gap == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      beat(p == 0, p == eop_at, fr_re[p], fr_im[p]);
    end
  endtask

  task automatic fill_ramp();
    for (int p = 0; p < LEN; p++) begin fr_re[p] = 16'(p); fr_im[p] = 16'(p); end
  endtask

  task automatic chk_peak(input string tag, input int idx, input longint mag, input int cnt);
    idle(4);
    chk({tag, "_peak_idx"}, peak_idx, idx);
    chk({tag, "_peak_mag"}, peak_mag, mag);
    chk({tag, "_frame_cnt"}, frame_cnt, cnt);
  endtask

  task automatic do_reset();
    rst_n = 0;
    m_in = 0; m_cnt = '0;
    exp_err.delete(); exp_mag.delete(); exp_pk.delete();
    #1;
    chk("rst_async_zero", |{fft_src_ready, mag_valid, mag_sop, mag_eop, mag_idx, mag_data,
                            peak_valid, peak_idx, peak_mag, frame_err, frame_cnt}, 0);
    repeat (3) @(posedge clk_100m);
    #1;
    rst_n = 1;
    rel_edge = edge_n;
    idle(2);
  endtask

  always @(negedge clk_100m) begin
    mexp_t me;
    pexp_t pe;
    int m;
    logic [6:0]  h_idx;
    logic [31:0] h_mag;
    logic [15:0] h_cnt;
    m = edge_n;
    if (!rst_n) begin
      h_idx = '0; h_mag = '0; h_cnt = '0;
      chk("reset_outputs", |{fft_src_ready, mag_valid, mag_sop, mag_eop, mag_idx, mag_data,
                           peak_valid, peak_idx, peak_mag, frame_err, frame_cnt}, 0);
    end else begin
      chk("ready", fft_src_ready, edge_n > rel_edge);
      chk("frame_err", frame_err, exp_err.exists(m));
      chk("mag_valid", mag_valid, exp_mag.exists(m));
      if (exp_mag.exists(m) && mag_valid) begin
        me = exp_mag[m];
        chk("mag_sop", mag_sop, me.sop);
        chk("mag_eop", mag_eop, me.eop);
        chk("mag_idx", mag_idx, me.idx);
        chk("mag_data", mag_data, me.data);
      end
      if (exp_pk.exists(m)) begin
        pe = exp_pk[m];
        h_idx = pe.idx; h_mag = pe.mag; h_cnt = pe.cnt;
      end
      chk("peak_valid", peak_valid, exp_pk.exists(m));
      chk("peak_idx", peak_idx, h_idx);
      chk("peak_mag", peak_mag, h_mag);
      chk("frame_cnt", frame_cnt, h_cnt);
    end
  end

  initial begin
    int kind, gap;
    #2;
    do_reset();

    // Good contiguous frame with bin 40 = (300,-400).
    fill_ramp();
    fr_re[40] = 16'sd300; fr_im[40] = -16'sd400;
    send_frame(LEN, LEN - 1, 0);
    chk_peak("good", 40, 250000, 1);

    // Full-scale negative bin.
    fill_ramp();
    fr_re[5] = 16'h8000; fr_im[5] = 16'h8000;
    send_frame(LEN, LEN - 1, 0);
    chk_peak("extreme", 5, 64'd2147483648, 2);

    // Ties inside window, larger DC and out-of-window bins.
    for (int p = 0; p < LEN; p++) begin fr_re[p] = '0; fr_im[p] = '0; end
    fr_re[0] = 16'sd1000; fr_im[0] = 16'sd1000;
    fr_re[10] = 16'sd100; fr_im[10] = 16'sd100;
    fr_re[20] = 16'sd100; fr_im[20] = -16'sd100;
    fr_re[100] = 16'sd2000;
    send_frame(LEN, LEN - 1, 0);
    chk_peak("ties", 10, 20000, 3);

    // Short frame, then a normal frame.
    fill_ramp();
    send_frame(100, 99, 0);
    chk_peak("short", 10, 20000, 3);
    send_frame(LEN, LEN - 1, 0);
    chk_peak("after_short", 63, 7938, 4);

    // sop at index 50 restarts the frame.
    send_frame(50, -1, 0);
    send_frame(LEN, LEN - 1, 0);
    chk_peak("restart", 63, 7938, 5);

    // Stray beats in IDLE then an alternately gapped frame.
    fr_re[40] = 16'sd300; fr_im[40] = -16'sd400;
    beat(0, 0, 16'sd7000, 16'sd7000);
    beat(0, 1, 16'sd9000, 16'sd9000);
    idle(1);
    beat(0, 0, 16'sd8000, 16'sd1);
    send_frame(LEN, LEN - 1, 1);
    chk_peak("gapped", 40, 250000, 6);

    // Reset asserted at bin 64, then a full frame.
    send_frame(64, -1, 0);
    do_reset();
    send_frame(LEN, LEN - 1, 0);
    chk_peak("post_reset", 40, 250000, 1);

    // Randomized framing, data and gaps.
    for (int f = 0; f < 24; f++) begin
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) beat(1'b0, 1'($urandom), rnd(), rnd());
      for (int p = 0; p < LEN; p++) begin fr_re[p] = rnd(); fr_im[p] = rnd(); end
      case (kind)
        0: send_frame(LEN, $urandom_range(1, LEN - 2), gap);
        1: send_frame(LEN, -1, gap);
        2: send_frame($urandom_range(1, LEN - 1), -1, gap);
        3: beat(1'b1, 1'b1, rnd(), rnd());
        default: send_frame(LEN, LEN - 1, gap);
      endcase
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 5));
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
